ps2_host_tx: RTL and testbench

- Host-to-device PS/2 command transmitter. It sends one byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard.
- It performs the request-to-send, shifts out data, parity and stop bits on device-generated clocks, and checks the device ACK.
- It sits beside the keyboard receive path on the same PS2_CLK/PS2_DATA pins and drives them open-drain through drive-low enables merged at top level.
- tx_busy lets the receive path ignore line activity during a transmission.

---
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_host_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-to-device PS/2 transmit bus: byte request/status handshake plus raw pins and open-drain enables.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift frame on device clocks, check ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic         clk,
  input logic         rst,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;

  // Synchronisers reset to 1 (idle bus) so reset release never looks like a fall.
  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall_c, timed_c, timeout_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= bus.ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= bus.ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall_c    = clk_prev & ~clk_sync;
  assign timed_c   = (state_q == S_RTS) || (state_q == S_SEND) ||
                     (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign timeout_c = timed_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    fail_d    = fail_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;

    if (timed_c) cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          shift_d  = {~^bus.tx_data, bus.tx_data};
          bit_d    = '0;
          fail_d   = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        data_oe_d = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        data_oe_d = data_oe_q;
        if (fall_c) begin
          if (bit_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            bit_d     = bit_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fall_c) begin
          fail_d  = data_sync;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          err_d   = fail_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout wins over any fall seen in the same cycle.
    if (timeout_c) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
      busy_d    = 1'b0;
      state_d   = S_IDLE;
    end
  end

  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: wired-AND pins, behavioural PS/2 device, scoreboard of expected frames.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 5000;

  typedef struct packed {
    logic [10:0] frame;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  ps2_host_tx_if bus();

  assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe  | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [10:0] obs_bits;
  exp_t        exp_q[$];

  always @(posedge clk) if (bus.tx_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Device: samples the line in the high phase before each fall; ACK pulls data low before fall 11.
  task automatic dev(input int n_falls, input bit nack);
    obs_bits = '0;
    for (int k = 0; k < n_falls; k++) begin
      step(10);
      obs_bits[k] = bus.ps2_data_in;
      if (k == 10 && !nack) dev_data_low = 1'b1;
      step(10);
      dev_clk_low = 1'b1;
      step(20);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic spam_start();
    repeat (6) begin
      step(25);
      bus.tx_data  = 8'h5A;
      bus.tx_start = 1'b1;
      step(1);
      bus.tx_start = 1'b0;
    end
  endtask

  // mode: 0 ack, 1 nack, 2 device silent, 3 tx_start spam, 4 reset after fall 4
  task automatic run_tx(input logic [7:0] d, input int mode, input string tag);
    int   n;
    int   d0;
    exp_t e;
    d0 = done_cnt;
    if (mode != 4) begin
      e.frame = {1'b1, ~^d, d, 1'b0};
      e.err   = (mode == 1) || (mode == 2);
      exp_q.push_back(e);
    end
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    step(1);
    bus.tx_start = 1'b0;
    check({tag, "_busy"}, 32'(bus.tx_busy), 32'd1);

    n = 0;
    while (bus.ps2_clk_oe && !bus.ps2_data_oe && n < 100) begin
      n++;
      step(1);
    end
    check({tag, "_inhibit_len"}, 32'(n), 32'(INH));
    check({tag, "_rts"}, 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b11);
    step(1);
    check({tag, "_send_start"}, 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b01);

    if (mode == 4) begin
      dev(4, 1'b0);
      step(3);
      #2 rst = 1'b0;
      #1;
      check({tag, "_async_release"}, 32'({bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_busy}), 32'b000);
      step(4);
      rst = 1'b1;
      step(5);
      check({tag, "_no_done"}, 32'(done_cnt), 32'(d0));
      return;
    end

    if (mode == 2) begin
      n = 1;
      while (!bus.tx_done && n < 6000) begin
        step(1);
        n++;
      end
      check({tag, "_timeout_cycles"}, 32'(n), 32'(TMO));
    end else begin
      if (mode == 3) begin
        fork
          dev(11, 1'b0);
          spam_start();
        join
      end else begin
        dev(11, mode == 1);
      end
      n = 0;
      while (!bus.tx_done && n < 200) begin
        step(1);
        n++;
      end
    end

    e = exp_q.pop_front();
    check({tag, "_done"}, 32'(bus.tx_done), 32'd1);
    check({tag, "_err"}, 32'(bus.tx_err), 32'(e.err));
    check({tag, "_idle_out"}, 32'({bus.tx_busy, bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b000);
    if (mode != 2) check({tag, "_frame"}, 32'(obs_bits), 32'(e.frame));
    step(3);
    check({tag, "_single_done"}, 32'({bus.tx_done, bus.tx_busy, bus.ps2_clk_oe}), 32'b000);
    check({tag, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    step(3);
    check("reset_outputs",
          32'({bus.tx_busy, bus.tx_done, bus.tx_err, bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b0);
    rst = 1'b1;
    step(3);
    check("idle_after_reset",
          32'({bus.tx_busy, bus.tx_done, bus.tx_err, bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b0);

    run_tx(8'hED, 0, "ed");
    run_tx(8'h00, 0, "d00");
    run_tx(8'h01, 0, "d01");
    run_tx(8'hFF, 0, "dff");
    run_tx(8'hA5, 1, "nack");
    run_tx(8'h3C, 2, "timeout");
    run_tx(8'h12, 3, "spam");
    run_tx(8'hAB, 4, "rst_mid");
    run_tx(8'hF4, 0, "f4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
